addr_region_mapper: RTL

- Parametrised successor to the fixed per-mapper address decoder.
- Translates SNES bus addresses through an MCU-programmable table of NUM_REGIONS match/translate regions.
- Emits ROM_ADDR, ROM_HIT, IS_WRITABLE and IS_SAVERAM through a 2-stage pipeline.
- Table is double-buffered: the MCU writes a shadow copy, and a commit swaps it in atomically between SNES accesses.

---
 rtl/addr_region_mapper.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/addr_region_mapper.sv
// SNES address region mapper: a double-buffered, MCU-programmed match/translate table
// feeding a 2-stage lookup pipeline. Define ADDR_REGION_HITCNT_EN for per-region hit counters.
//
// Handshake: SNES_ADDR_VALID is a one-cycle strobe with no backpressure. Each strobe produces
// exactly one OUT_VALID pulse two cycles later. Between pulses the result outputs hold.
module addr_region_mapper #(
  parameter int NUM_REGIONS = 8,
  parameter int IDX_W       = 3,
  parameter int ADDR_W      = 24
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] SNES_ADDR,
  input  logic              SNES_ADDR_VALID,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [1:0]        cfg_field,
  input  logic [ADDR_W-1:0] cfg_data,
  input  logic              cfg_commit,
`ifdef ADDR_REGION_HITCNT_EN
  input  logic [IDX_W-1:0]  cnt_idx,
  output logic [15:0]       cnt_value,
`endif
  output logic              cfg_busy,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic              ROM_HIT,
  output logic              IS_WRITABLE,
  output logic              IS_SAVERAM,
  output logic [IDX_W-1:0]  REGION_ID,
  output logic              OUT_VALID
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  localparam int FLAG_EN = 0;
  localparam int FLAG_WR = 1;
  localparam int FLAG_SR = 2;

  localparam logic [1:0] FIELD_BASE   = 2'd0;
  localparam logic [1:0] FIELD_MASK   = 2'd1;
  localparam logic [1:0] FIELD_TARGET = 2'd2;
  localparam logic [1:0] FIELD_FLAGS  = 2'd3;

  // Shadow (MCU-written) and active (lookup-visible) tables
  logic [ADDR_W-1:0] sh_base_q   [NUM_REGIONS];
  logic [ADDR_W-1:0] sh_base_d   [NUM_REGIONS];
  logic [ADDR_W-1:0] sh_mask_q   [NUM_REGIONS];
  logic [ADDR_W-1:0] sh_mask_d   [NUM_REGIONS];
  logic [ADDR_W-1:0] sh_target_q [NUM_REGIONS];
  logic [ADDR_W-1:0] sh_target_d [NUM_REGIONS];
  logic [2:0]        sh_flags_q  [NUM_REGIONS];
  logic [2:0]        sh_flags_d  [NUM_REGIONS];

  logic [ADDR_W-1:0] act_base_q   [NUM_REGIONS];
  logic [ADDR_W-1:0] act_base_d   [NUM_REGIONS];
  logic [ADDR_W-1:0] act_mask_q   [NUM_REGIONS];
  logic [ADDR_W-1:0] act_mask_d   [NUM_REGIONS];
  logic [ADDR_W-1:0] act_target_q [NUM_REGIONS];
  logic [ADDR_W-1:0] act_target_d [NUM_REGIONS];
  logic [2:0]        act_flags_q  [NUM_REGIONS];
  logic [2:0]        act_flags_d  [NUM_REGIONS];

  logic [0:0] state_q, state_d;
  logic       copy_en;
  logic       cfg_wr_ok;

  // Stage 1 registers
  logic              s1_valid_q, s1_valid_d;
  logic              s1_hit_q, s1_hit_d;
  logic [IDX_W-1:0]  s1_idx_q, s1_idx_d;
  logic [ADDR_W-1:0] s1_target_q, s1_target_d;
  logic [ADDR_W-1:0] s1_offset_q, s1_offset_d;
  logic              s1_wr_q, s1_wr_d;
  logic              s1_sr_q, s1_sr_d;

  // Stage 2 (output) registers
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rom_hit_q, rom_hit_d;
  logic              is_wr_q, is_wr_d;
  logic              is_sr_q, is_sr_d;
  logic [IDX_W-1:0]  region_id_q, region_id_d;

  // Lookup combinational results
  logic              lk_hit;
  logic [IDX_W-1:0]  lk_idx;
  logic [ADDR_W-1:0] lk_target;
  logic [ADDR_W-1:0] lk_mask;
  logic [2:0]        lk_flags;

  assign cfg_wr_ok = cfg_we && (state_q == ST_IDLE);

  always_comb begin
    sh_base_d   = sh_base_q;
    sh_mask_d   = sh_mask_q;
    sh_target_d = sh_target_q;
    sh_flags_d  = sh_flags_q;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (cfg_wr_ok && (cfg_idx == IDX_W'(i))) begin
        case (cfg_field)
          FIELD_BASE:   sh_base_d[i]   = cfg_data;
          FIELD_MASK:   sh_mask_d[i]   = cfg_data;
          FIELD_TARGET: sh_target_d[i] = cfg_data;
          FIELD_FLAGS:  sh_flags_d[i]  = cfg_data[2:0];
          default:      sh_flags_d[i]  = sh_flags_q[i];
        endcase
      end
    end
  end

  // The copy never lands on an edge that samples a lookup, so each lookup sees one whole table.
  always_comb begin
    state_d = state_q;
    copy_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_commit) begin
          if (SNES_ADDR_VALID) state_d = ST_PENDING;
          else                 copy_en = 1'b1;
        end
      end
      ST_PENDING: begin
        if (!SNES_ADDR_VALID) begin
          copy_en = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Copy from the post-write shadow so a same-cycle write is part of the commit.
  always_comb begin
    act_base_d   = act_base_q;
    act_mask_d   = act_mask_q;
    act_target_d = act_target_q;
    act_flags_d  = act_flags_q;
    if (copy_en) begin
      act_base_d   = sh_base_d;
      act_mask_d   = sh_mask_d;
      act_target_d = sh_target_d;
      act_flags_d  = sh_flags_d;
    end
  end

  // Descending scan so the lowest matching index wins.
  always_comb begin
    lk_hit    = 1'b0;
    lk_idx    = '0;
    lk_target = '0;
    lk_mask   = '0;
    lk_flags  = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (act_flags_q[i][FLAG_EN] &&
          ((SNES_ADDR & act_mask_q[i]) == (act_base_q[i] & act_mask_q[i]))) begin
        lk_hit    = 1'b1;
        lk_idx    = IDX_W'(i);
        lk_target = act_target_q[i];
        lk_mask   = act_mask_q[i];
        lk_flags  = act_flags_q[i];
      end
    end
  end

  always_comb begin
    s1_valid_d  = SNES_ADDR_VALID;
    s1_hit_d    = s1_hit_q;
    s1_idx_d    = s1_idx_q;
    s1_target_d = s1_target_q;
    s1_offset_d = s1_offset_q;
    s1_wr_d     = s1_wr_q;
    s1_sr_d     = s1_sr_q;
    if (SNES_ADDR_VALID) begin
      s1_hit_d    = lk_hit;
      s1_idx_d    = lk_idx;
      s1_target_d = lk_target;
      s1_offset_d = lk_hit ? (SNES_ADDR & ~lk_mask) : '0;
      s1_wr_d     = lk_flags[FLAG_WR];
      s1_sr_d     = lk_flags[FLAG_SR];
    end
  end

  // A miss carries zero target/offset/flags, so the sum below yields 0.
  always_comb begin
    out_valid_d = s1_valid_q;
    rom_addr_d  = rom_addr_q;
    rom_hit_d   = rom_hit_q;
    is_wr_d     = is_wr_q;
    is_sr_d     = is_sr_q;
    region_id_d = region_id_q;
    if (s1_valid_q) begin
      rom_addr_d  = s1_target_q + s1_offset_q;
      rom_hit_d   = s1_hit_q;
      is_wr_d     = s1_wr_q;
      is_sr_d     = s1_sr_q;
      region_id_d = s1_idx_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        sh_base_q[i]    <= '0;
        sh_mask_q[i]    <= '0;
        sh_target_q[i]  <= '0;
        sh_flags_q[i]   <= '0;
        act_base_q[i]   <= '0;
        act_mask_q[i]   <= '0;
        act_target_q[i] <= '0;
        act_flags_q[i]  <= '0;
      end
      state_q     <= ST_IDLE;
      s1_valid_q  <= 1'b0;
      s1_hit_q    <= 1'b0;
      s1_idx_q    <= '0;
      s1_target_q <= '0;
      s1_offset_q <= '0;
      s1_wr_q     <= 1'b0;
      s1_sr_q     <= 1'b0;
      out_valid_q <= 1'b0;
      rom_addr_q  <= '0;
      rom_hit_q   <= 1'b0;
      is_wr_q     <= 1'b0;
      is_sr_q     <= 1'b0;
      region_id_q <= '0;
    end else begin
      sh_base_q    <= sh_base_d;
      sh_mask_q    <= sh_mask_d;
      sh_target_q  <= sh_target_d;
      sh_flags_q   <= sh_flags_d;
      act_base_q   <= act_base_d;
      act_mask_q   <= act_mask_d;
      act_target_q <= act_target_d;
      act_flags_q  <= act_flags_d;
      state_q      <= state_d;
      s1_valid_q   <= s1_valid_d;
      s1_hit_q     <= s1_hit_d;
      s1_idx_q     <= s1_idx_d;
      s1_target_q  <= s1_target_d;
      s1_offset_q  <= s1_offset_d;
      s1_wr_q      <= s1_wr_d;
      s1_sr_q      <= s1_sr_d;
      out_valid_q  <= out_valid_d;
      rom_addr_q   <= rom_addr_d;
      rom_hit_q    <= rom_hit_d;
      is_wr_q      <= is_wr_d;
      is_sr_q      <= is_sr_d;
      region_id_q  <= region_id_d;
    end
  end

`ifdef ADDR_REGION_HITCNT_EN
  logic [15:0] cnt_q [NUM_REGIONS];
  logic [15:0] cnt_d [NUM_REGIONS];

  // A commit clears the counters even if a hit retires on the same edge.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (copy_en) begin
        cnt_d[i] = '0;
      end else if (s1_valid_q && s1_hit_q && (s1_idx_q == IDX_W'(i)) &&
                   (cnt_q[i] != 16'hFFFF)) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    cnt_value = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (cnt_idx == IDX_W'(i)) cnt_value = cnt_q[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGIONS; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign cfg_busy    = (state_q == ST_PENDING);
  assign ROM_ADDR    = rom_addr_q;
  assign ROM_HIT     = rom_hit_q;
  assign IS_WRITABLE = is_wr_q;
  assign IS_SAVERAM  = is_sr_q;
  assign REGION_ID   = region_id_q;
  assign OUT_VALID   = out_valid_q;

endmodule
